vlan_etype_parser: RTL and testbench
====================================

Name: vlan_etype_parser

Overview:
- Successor to the single-field ETYPE parser: walks up to MAX_VLAN_TAGS stacked 802.1Q/802.1ad tags to find the inner EtherType.
- Also reports tag count and outer VID, and matches the inner EtherType against NUM_CONFIG_ETYPES programmable values.
- Sits in the NMU ingress path after MAC parsing. Data passes through a one-stage register slice; the parse result is attached to the tlast beat.

Parameters:
- AXIS_BUS_WIDTH, 64, data width in bits; multiple of 16, ≥16, so 16-bit fields at even offsets never straddle beats.
- AXIS_ID_WIDTH, 4, tid width (effective width max(1,·)).
- AXIS_DEST_WIDTH, 0, tdest width (effective width max(1,·)).
- MAX_VLAN_TAGS, 2, maximum tags walked (1..4).
- NUM_CONFIG_ETYPES, 2, programmable EtherType comparators.
- Derived: VC = $clog2(MAX_VLAN_TAGS+1); TUSER_OUT_WIDTH = 32+VC+NUM_CONFIG_ETYPES.

Ports:
- aclk  in  1  clock
- areset  in  1  synchronous active-high reset
- axis_in_tdata/tkeep/tid/tdest/tlast/tvalid  in  per params  input stream; tkeep all-ones except on the tlast beat
- axis_in_tready  out  1  input ready
- axis_out_tdata/tkeep/tid/tdest/tlast/tvalid  out  per params  registered copy of the input stream
- axis_out_tuser  out  TUSER_OUT_WIDTH  parse result. LSB first: etype[15:0], outer_vid[27:16], vlan_cnt[VC], cfg_match[N], etype_valid, runt, tag_overflow, drop.
- axis_out_tready  in  1  output ready
- cfg_etypes  in  16*NUM_CONFIG_ETYPES  comparator values
- cfg_etype_en  in  NUM_CONFIG_ETYPES  comparator enables
- cfg_drop_unknown, cfg_drop_runt, cfg_drop_overflow  in  1 each  drop policy

Behaviour:
- Handshake:
  - axis_in_tready = !axis_out_tvalid || axis_out_tready.
  - A beat is accepted on in_tvalid && in_tready.
  - Accepted beats appear on the output next cycle (latency 1) with tdata/tkeep/tid/tdest/tlast unchanged.
  - Output holds stable while tvalid && !tready.
  - Full throughput when out_tready is held high.
- Reset: out_tvalid=0, out_tuser=0, all other out fields 0, beat counter=0, captured fields cleared. Reset mid-packet discards the packet; the first beat accepted after reset is treated as a packet start.
- Beat counter: counts accepted beats and clears on accepted tlast. Saturates at its max; width is sized for offset 12+4*MAX_VLAN_TAGS+2.
- Field capture: for k=0..MAX_VLAN_TAGS, field Fk sits at byte offset 12+4k (big-endian, byte 0 = tdata[7:0]). Fk is captured on the beat containing it, only if its bytes are covered by tkeep. Also capture the TCI at 14..15 (bits [11:0] give the outer VID).
- Resolution: combinational from captured regs merged with the current beat; registered with the tlast beat.
  - Walk k upward. While Fk ∈ {0x8100, 0x88A8} and k < MAX_VLAN_TAGS, advance k.
  - vlan_cnt = tags consumed.
  - etype = the terminating Fk.
  - tag_overflow = 1 if F_MAX is still a TPID; etype then reports that TPID.
  - outer_vid = TCI[11:0] when vlan_cnt ≥ 1, else 0.
  - runt = 1 if tlast arrives before the required field was captured; etype_valid = !runt. On runt: etype=0, vlan_cnt = tags confirmed so far.
  - cfg_match[i] = etype_valid && cfg_etype_en[i] && etype==cfg_etypes[i].
  - unknown = etype_valid && !|cfg_match.
  - drop = (runt&cfg_drop_runt) | (unknown&cfg_drop_unknown) | (tag_overflow&cfg_drop_overflow).
- axis_out_tuser is all zeros on non-tlast beats. A single-beat packet resolves and is marked on that same beat.
- Config inputs are sampled on the tlast-accept cycle; changes mid-packet affect only the result of the packet whose tlast is accepted after the change.
- Back-to-back packets: parse state clears on accepted tlast, so the next beat starts a new packet with no bubble.

Test Plan:
- Untagged IPv4, 64-byte frame, bus 64, cfg_etypes={0x0800,0x86DD}, en=11 -> tlast tuser: etype=0x0800, vlan_cnt=0, vid=0, match=01, valid=1, drop=0; 8 beats out, latency 1.
- Single 0x8100 tag with TCI 0x2123, inner 0x86DD -> etype=0x86DD, vlan_cnt=1, outer_vid=0x123, match=10.
- QinQ 0x88A8/0x8100, inner 0x0806, cfg_drop_unknown=1 -> vlan_cnt=2, match=00, drop=1.
- Three tags with MAX_VLAN_TAGS=2, cfg_drop_overflow=1 -> etype=0x8100, tag_overflow=1, drop=1; repeat at bus 16 and bus 128 with identical results.
- 10-byte runt (tlast on beat 2, tkeep=0x03), cfg_drop_runt=1 -> runt=1, etype_valid=0, etype=0, drop=1.
- Random out_tready (50%) plus areset asserted on beat 3 of 6 -> no beat lost or duplicated, data matches a scoreboard, outputs are 0 the cycle after reset, and the next packet parses correctly.

Source files
------------

// File: rtl/vlan_etype_parser.sv
// vlan_etype_parser: walks stacked VLAN tags to the inner EtherType and tags the tlast beat with the parse result
module vlan_etype_parser #(
    parameter int AXIS_BUS_WIDTH    = 64,
    parameter int AXIS_ID_WIDTH     = 4,
    parameter int AXIS_DEST_WIDTH   = 0,
    parameter int MAX_VLAN_TAGS     = 2,
    parameter int NUM_CONFIG_ETYPES = 2,
    localparam int VC               = $clog2(MAX_VLAN_TAGS + 1),
    localparam int TUSER_OUT_WIDTH  = 32 + VC + NUM_CONFIG_ETYPES,
    localparam int IW               = AXIS_ID_WIDTH > 0 ? AXIS_ID_WIDTH : 1,
    localparam int DW               = AXIS_DEST_WIDTH > 0 ? AXIS_DEST_WIDTH : 1,
    localparam int KW               = AXIS_BUS_WIDTH / 8
) (
    input  logic                           aclk,
    input  logic                           areset,
    input  logic [AXIS_BUS_WIDTH-1:0]      axis_in_tdata,
    input  logic [KW-1:0]                  axis_in_tkeep,
    input  logic [IW-1:0]                  axis_in_tid,
    input  logic [DW-1:0]                  axis_in_tdest,
    input  logic                           axis_in_tlast,
    input  logic                           axis_in_tvalid,
    output logic                           axis_in_tready,
    output logic [AXIS_BUS_WIDTH-1:0]      axis_out_tdata,
    output logic [KW-1:0]                  axis_out_tkeep,
    output logic [IW-1:0]                  axis_out_tid,
    output logic [DW-1:0]                  axis_out_tdest,
    output logic                           axis_out_tlast,
    output logic                           axis_out_tvalid,
    output logic [TUSER_OUT_WIDTH-1:0]     axis_out_tuser,
    input  logic                           axis_out_tready,
    input  logic [16*NUM_CONFIG_ETYPES-1:0] cfg_etypes,
    input  logic [NUM_CONFIG_ETYPES-1:0]   cfg_etype_en,
    input  logic                           cfg_drop_unknown,
    input  logic                           cfg_drop_runt,
    input  logic                           cfg_drop_overflow
);
    localparam int NF = MAX_VLAN_TAGS + 1;
    localparam int CW = $clog2((14 + 4 * MAX_VLAN_TAGS) / KW + 2);
    localparam int TL = 14 % KW;
    logic                         accept;
    logic [CW-1:0]                beat_cnt;
    logic [NF-1:0][15:0]          fld, cur;
    logic [NF-1:0]                fld_v, hit;
    logic [11:0]                  tci, cur_tci;
    logic                         tci_v, tci_hit;
    logic [15:0]                  etype, eff;
    logic [VC-1:0]                vcnt;
    logic [11:0]                  vid;
    logic [NUM_CONFIG_ETYPES-1:0] match;
    logic                         runt, ovf, valid, unknown, drop, done, tpid;
    logic [TUSER_OUT_WIDTH-1:0]   result;

    assign axis_in_tready = !axis_out_tvalid || axis_out_tready;
    assign accept = axis_in_tvalid && axis_in_tready;

    for (genvar k = 0; k < NF; k++) begin : g_fld
        localparam int OFF = 12 + 4 * k;
        localparam int LN  = OFF % KW;
        assign hit[k] = beat_cnt == CW'(OFF / KW) && &axis_in_tkeep[LN +: 2];
        assign cur[k] = {axis_in_tdata[8*LN +: 8], axis_in_tdata[8*LN+8 +: 8]};
    end

    assign tci_hit = beat_cnt == CW'(14 / KW) && &axis_in_tkeep[TL +: 2];
    assign cur_tci = {axis_in_tdata[8*TL +: 4], axis_in_tdata[8*TL+8 +: 8]};

    // Tag walk over captured fields merged with the current beat, then match and drop policy
    always_comb begin
        vcnt = '0;
        etype = '0;
        eff = '0;
        runt = 1'b0;
        ovf = 1'b0;
        done = 1'b0;
        tpid = 1'b0;
        for (int k = 0; k < NF; k++) begin
            eff = hit[k] ? cur[k] : fld[k];
            tpid = eff == 16'h8100 || eff == 16'h88A8;
            if (!done) begin
                if (!(hit[k] || fld_v[k])) begin
                    runt = 1'b1;
                    done = 1'b1;
                end else if (tpid && k < MAX_VLAN_TAGS) begin
                    vcnt = vcnt + VC'(1);
                end else begin
                    etype = eff;
                    ovf = tpid;
                    done = 1'b1;
                end
            end
        end
        valid = !runt;
        for (int i = 0; i < NUM_CONFIG_ETYPES; i++)
            match[i] = valid && cfg_etype_en[i] && etype == cfg_etypes[16*i +: 16];
        unknown = valid && !(|match);
        drop = (runt && cfg_drop_runt) || (unknown && cfg_drop_unknown) || (ovf && cfg_drop_overflow);
        vid = vcnt == '0 ? 12'h0 : tci_hit ? cur_tci : tci_v ? tci : 12'h0;
        result = {drop, ovf, runt, valid, match, vcnt, vid, etype};
    end

    // Parse state: beat counter and field captures, restarted after every accepted tlast
    always_ff @(posedge aclk) begin
        if (areset) begin
            beat_cnt <= '0;
            fld <= '0;
            fld_v <= '0;
            tci <= '0;
            tci_v <= 1'b0;
        end else if (accept) begin
            if (axis_in_tlast) begin
                beat_cnt <= '0;
                fld_v <= '0;
                tci_v <= 1'b0;
            end else begin
                beat_cnt <= &beat_cnt ? beat_cnt : beat_cnt + CW'(1);
                for (int k = 0; k < NF; k++) begin
                    if (hit[k]) begin
                        fld[k] <= cur[k];
                        fld_v[k] <= 1'b1;
                    end
                end
                if (tci_hit) begin
                    tci <= cur_tci;
                    tci_v <= 1'b1;
                end
            end
        end
    end

    // Output register slice; parse result rides only on the tlast beat
    always_ff @(posedge aclk) begin
        if (areset) begin
            axis_out_tvalid <= 1'b0;
            axis_out_tdata <= '0;
            axis_out_tkeep <= '0;
            axis_out_tid <= '0;
            axis_out_tdest <= '0;
            axis_out_tlast <= 1'b0;
            axis_out_tuser <= '0;
        end else if (accept) begin
            axis_out_tvalid <= 1'b1;
            axis_out_tdata <= axis_in_tdata;
            axis_out_tkeep <= axis_in_tkeep;
            axis_out_tid <= axis_in_tid;
            axis_out_tdest <= axis_in_tdest;
            axis_out_tlast <= axis_in_tlast;
            axis_out_tuser <= axis_in_tlast ? result : '0;
        end else if (axis_out_tready) begin
            axis_out_tvalid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_vlan_etype_parser.sv
// tb_vlan_etype_parser: directed frames against hand-computed parse results and a beat scoreboard
module tb_vlan_etype_parser;
    localparam int UW = 36;
    localparam int EW = 64 + 8 + 4 + 1 + 1 + UW;
    logic            aclk = 1'b0;
    logic            areset = 1'b1;
    logic [63:0]     in_tdata = '0;
    logic [7:0]      in_tkeep = '0;
    logic [3:0]      in_tid = '0;
    logic [0:0]      in_tdest = '0;
    logic            in_tlast = 1'b0;
    logic            in_tvalid = 1'b0;
    logic            in_tready;
    logic [63:0]     out_tdata;
    logic [7:0]      out_tkeep;
    logic [3:0]      out_tid;
    logic [0:0]      out_tdest;
    logic            out_tlast, out_tvalid;
    logic [UW-1:0]   out_tuser;
    logic            out_tready;
    logic [31:0]     cfg_etypes = {16'h86DD, 16'h0800};
    logic [1:0]      cfg_etype_en = 2'b11;
    logic            cfg_drop_unknown = 1'b0, cfg_drop_runt = 1'b0, cfg_drop_overflow = 1'b0;
    logic            rnd_rdy = 1'b0;
    logic            alt_go = 1'b0;
    logic [7:0]      frm [0:255];
    int              flen = 0;
    int              checks = 0, errors = 0;
    time             t_acc, t0, t_last;
    logic [EW-1:0]   expq [$];

    always #5 aclk = ~aclk;

    vlan_etype_parser dut (
        .aclk(aclk), .areset(areset),
        .axis_in_tdata(in_tdata), .axis_in_tkeep(in_tkeep), .axis_in_tid(in_tid),
        .axis_in_tdest(in_tdest), .axis_in_tlast(in_tlast), .axis_in_tvalid(in_tvalid),
        .axis_in_tready(in_tready),
        .axis_out_tdata(out_tdata), .axis_out_tkeep(out_tkeep), .axis_out_tid(out_tid),
        .axis_out_tdest(out_tdest), .axis_out_tlast(out_tlast), .axis_out_tvalid(out_tvalid),
        .axis_out_tuser(out_tuser), .axis_out_tready(out_tready),
        .cfg_etypes(cfg_etypes), .cfg_etype_en(cfg_etype_en), .cfg_drop_unknown(cfg_drop_unknown),
        .cfg_drop_runt(cfg_drop_runt), .cfg_drop_overflow(cfg_drop_overflow)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [UW-1:0] mk(input logic [15:0] et, input logic [11:0] vid,
        input logic [1:0] cnt, input logic [1:0] m, input logic v, input logic r,
        input logic o, input logic d);
        return {d, o, r, v, m, cnt, vid, et};
    endfunction

    task automatic build(input int len, input logic [7:0] seed);
        flen = len;
        for (int i = 0; i < len; i++) frm[i] = 8'(i * 13) ^ seed;
    endtask

    task automatic put16(input int off, input logic [15:0] v);
        frm[off] = v[15:8];
        frm[off+1] = v[7:0];
    endtask

    task automatic beat(input logic [63:0] d, input logic [7:0] k, input logic [3:0] id,
        input logic l, input logic [UW-1:0] u);
        int n = 0;
        logic acc = 1'b0;
        in_tdata = d;
        in_tkeep = k;
        in_tid = id;
        in_tlast = l;
        in_tvalid = 1'b1;
        while (!acc && n < 200) begin
            @(negedge aclk);
            acc = in_tready;
            @(posedge aclk);
            if (acc) begin
                expq.push_back({d, k, id, 1'b0, l, u});
                t_acc = $time;
            end
            #1;
            n++;
        end
        if (!acc) check("accept_timeout", 0, 1);
        in_tvalid = 1'b0;
    endtask

    task automatic send(input logic [3:0] id, input logic [UW-1:0] eu, input int stop_at);
        for (int b = 0; b * 8 < flen; b++) begin
            logic [63:0] d;
            logic [7:0] k;
            logic l;
            if (b == stop_at) break;
            d = '0;
            k = '0;
            for (int j = 0; j < 8; j++) begin
                if (b * 8 + j < flen) begin
                    d[8*j +: 8] = frm[b*8+j];
                    k[j] = 1'b1;
                end
            end
            l = (b + 1) * 8 >= flen;
            beat(d, k, id, l, l ? eu : '0);
            if (b == 0) t0 = t_acc;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (expq.size() != 0 && n < 500) begin
            @(posedge aclk);
            n++;
        end
        #1;
        check("drain", 128'(expq.size()), 0);
    endtask

    initial begin
        out_tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            out_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        logic [EW-1:0] e;
        forever begin
            @(negedge aclk);
            if (out_tvalid && out_tready) begin
                if (expq.size() == 0) begin
                    check("extra_beat", 1, 0);
                end else begin
                    e = expq.pop_front();
                    check("beat", {out_tdata, out_tkeep, out_tid, out_tdest, out_tlast, out_tuser}, e);
                end
                if (out_tlast) t_last = $time;
            end
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_alt
        localparam int AW = g ? 128 : 16;
        localparam int AB = AW / 8;
        logic [AW-1:0] td, otd;
        logic [AB-1:0] tk, otk;
        logic [3:0]    oid;
        logic [0:0]    odst;
        logic          tl, tv, trdy, ol, ov;
        logic [UW-1:0] ou;
        logic [UW:0]   res;
        logic          done;
        vlan_etype_parser #(.AXIS_BUS_WIDTH(AW)) u_alt (
            .aclk(aclk), .areset(areset),
            .axis_in_tdata(td), .axis_in_tkeep(tk), .axis_in_tid(4'd0),
            .axis_in_tdest(1'b0), .axis_in_tlast(tl), .axis_in_tvalid(tv),
            .axis_in_tready(trdy),
            .axis_out_tdata(otd), .axis_out_tkeep(otk), .axis_out_tid(oid),
            .axis_out_tdest(odst), .axis_out_tlast(ol), .axis_out_tvalid(ov),
            .axis_out_tuser(ou), .axis_out_tready(1'b1),
            .cfg_etypes(cfg_etypes), .cfg_etype_en(cfg_etype_en), .cfg_drop_unknown(cfg_drop_unknown),
            .cfg_drop_runt(cfg_drop_runt), .cfg_drop_overflow(cfg_drop_overflow)
        );
        initial begin
            td = '0;
            tk = '0;
            tl = 1'b0;
            tv = 1'b0;
            res = '0;
            done = 1'b0;
            wait (alt_go);
            for (int b = 0; b * AB < flen; b++) begin
                for (int j = 0; j < AB; j++) begin
                    td[8*j +: 8] = b * AB + j < flen ? frm[b*AB+j] : 8'h00;
                    tk[j] = b * AB + j < flen;
                end
                tl = (b + 1) * AB >= flen;
                tv = 1'b1;
                @(posedge aclk);
                #1;
            end
            tv = 1'b0;
            res = {ov && ol, ou};
            done = 1'b1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic [UW-1:0] e4;
        int n;
        repeat (3) @(posedge aclk);
        #1;
        check("reset_tvalid", out_tvalid, 0);
        check("reset_tuser", out_tuser, 0);
        check("reset_tdata", out_tdata, 0);
        areset = 1'b0;

        build(64, 8'h11);
        put16(12, 16'h0800);
        send(4'd1, mk(16'h0800, 12'h0, 2'd0, 2'b01, 1, 0, 0, 0), -1);
        drain();
        check("latency_8beats", 128'(t_last - t0), 75);

        cfg_drop_unknown = 1'b1;
        build(64, 8'h22);
        put16(12, 16'h8100);
        put16(14, 16'h2123);
        put16(16, 16'h86DD);
        send(4'd2, mk(16'h86DD, 12'h123, 2'd1, 2'b10, 1, 0, 0, 0), -1);
        build(64, 8'h33);
        put16(12, 16'h88A8);
        put16(14, 16'h0005);
        put16(16, 16'h8100);
        put16(18, 16'h0007);
        put16(20, 16'h0806);
        send(4'd3, mk(16'h0806, 12'h005, 2'd2, 2'b00, 1, 0, 0, 1), -1);
        drain();

        cfg_drop_unknown = 1'b0;
        cfg_drop_overflow = 1'b1;
        build(64, 8'h44);
        put16(12, 16'h8100);
        put16(14, 16'h0ABC);
        put16(16, 16'h8100);
        put16(20, 16'h8100);
        put16(24, 16'h0800);
        e4 = mk(16'h8100, 12'hABC, 2'd2, 2'b00, 1, 0, 1, 1);
        alt_go = 1'b1;
        send(4'd4, e4, -1);
        drain();
        n = 0;
        while (!(g_alt[0].done && g_alt[1].done) && n < 1000) begin
            @(posedge aclk);
            n++;
        end
        #1;
        check("ovf_bus16", g_alt[0].res, {1'b1, e4});
        check("ovf_bus128", g_alt[1].res, {1'b1, e4});
        cfg_drop_overflow = 1'b0;

        cfg_drop_runt = 1'b1;
        build(10, 8'h55);
        send(4'd6, mk(16'h0, 12'h0, 2'd0, 2'b00, 0, 1, 0, 1), -1);
        drain();
        cfg_drop_runt = 1'b0;
        build(16, 8'h66);
        put16(12, 16'h8100);
        put16(14, 16'h3456);
        send(4'd7, mk(16'h0, 12'h456, 2'd1, 2'b00, 0, 1, 0, 0), -1);
        build(14, 8'h77);
        put16(12, 16'h86DD);
        send(4'd8, mk(16'h86DD, 12'h0, 2'd0, 2'b10, 1, 0, 0, 0), -1);
        drain();

        rnd_rdy = 1'b1;
        build(48, 8'h88);
        put16(12, 16'h0800);
        send(4'd9, '0, 3);
        areset = 1'b1;
        @(posedge aclk);
        #1;
        expq.delete();
        areset = 1'b0;
        check("midrst_tvalid", out_tvalid, 0);
        check("midrst_tuser", out_tuser, 0);
        check("midrst_tdata", out_tdata, 0);
        build(64, 8'h99);
        put16(12, 16'h8100);
        put16(14, 16'h2123);
        put16(16, 16'h86DD);
        send(4'd10, mk(16'h86DD, 12'h123, 2'd1, 2'b10, 1, 0, 0, 0), -1);
        drain();
        rnd_rdy = 1'b0;
        repeat (3) @(posedge aclk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
